mac_tap_sequencer: RTL
======================

# mac_tap_sequencer

Sequences one polyphase FIR output in the sample-rate converter datapath. On each `start`, it loads the coefficient address counter with the phase's coefficient pointer. It then steps that counter and a data ring-buffer read address together for `tap_num` taps, and drives the MAC enable/clear strobes with the one-cycle RAM read latency compensated. It sits between the phase scheduler, which issues `start`, and the coefficient counter, sample RAM and MAC datapath.

## Interface
- `DATA_ADDRESS_WIDTH`, 12, width of coefficient and sample RAM addresses
- `TAP_CNT_WIDTH`, 8, width of the tap count
- `clk`  in  1  single clock; all logic on rising edge
- `clr_n`  in  1  reset, asynchronous, active-low
- `start`  in  1  request one convolution; sampled only when `busy`=0
- `abort`  in  1  synchronous cancel of the current convolution
- `coef_ptr`  in  DATA_ADDRESS_WIDTH  first coefficient address of the phase
- `data_ptr`  in  DATA_ADDRESS_WIDTH  newest sample address in the ring
- `buf_base`  in  DATA_ADDRESS_WIDTH  ring window base address
- `buf_len`  in  DATA_ADDRESS_WIDTH  ring window length, in words
- `tap_num`  in  TAP_CNT_WIDTH  number of taps N
- `busy`  out  1  convolution in progress
- `coef_load`  out  1  load strobe to the coefficient counter
- `coef_cnt`  out  1  count/enable to the coefficient counter; its address is valid while this is high
- `coef_ptr_o`  out  DATA_ADDRESS_WIDTH  registered copy of `coef_ptr`, held during LOAD
- `data_rd`  out  1  sample RAM read enable
- `data_addr`  out  DATA_ADDRESS_WIDTH  sample RAM read address
- `mac_en`  out  1  MAC accumulate enable, aligned to RAM read data
- `mac_first`  out  1  first product; the MAC loads instead of accumulating
- `done`  out  1  one-cycle pulse, result complete
- `err`  out  1  one-cycle pulse with `done`, request rejected

## Operation
- States: IDLE, LOAD, RUN, DRAIN, DONE.
- **IDLE:**
  - `start`=1 with `tap_num`≠0 and `data_ptr` in the window: latch all inputs, go to LOAD.
  - `tap_num`=0: go to DONE with `err`=0. No counter or MAC activity occurs, and the consumer treats the result as zero.
  - `data_ptr` outside the window [`buf_base`, `buf_base`+`buf_len`-1], or `buf_len`=0: go to DONE with `err`=1.
- **LOAD** (1 cycle): `coef_load`=1, `coef_cnt`=0, `coef_ptr_o`=latched pointer; `data_addr` is preloaded with `data_ptr`.
- **RUN** (N cycles, k=0..N-1):
  - `coef_cnt`=1 and `data_rd`=1.
  - `data_addr` = `buf_base` + ((`data_ptr` − `buf_base` − k) mod `buf_len`).
  - Wrap rule: when `data_addr`=`buf_base`, the next address is `buf_base`+`buf_len`-1; otherwise it is `data_addr`-1.
  - An internal tap counter decrements; RUN→DRAIN when it reaches 1.
- **DRAIN** (1 cycle): no reads.
- **DONE** (1 cycle): `done`=1, then go to IDLE.
- `coef_load` and `coef_cnt` are never high in the same cycle.
- `mac_en` is `data_rd` delayed by one cycle. `mac_first` is high with the first `mac_en` only.
- **`abort`:**
  - In LOAD, RUN or DRAIN: go to IDLE next edge; `coef_cnt`, `data_rd` and `mac_en` are low from that edge; no `done`.
  - In IDLE or DONE: ignored.
- `start` while `busy`=1 is ignored and does not queue.
- Address arithmetic is done in DATA_ADDRESS_WIDTH bits, modulo 2^DATA_ADDRESS_WIDTH. `tap_num` > `buf_len` wraps repeatedly, as defined above.

## Timing
- Cycle convention: `start` is high in cycle 0.
- LOAD is cycle 1; RUN is cycles 2..N+1; `mac_en` is high in cycles 3..N+2; `done` is in cycle N+3.
- `busy`=1 in cycles 1..N+3. The next `start` is accepted in cycle N+4 or later, which gives N+4 cycles per convolution back-to-back.
- Rejected or zero-tap request: `busy`=1 and `done`=1 (with `err` per the rule above) in cycle 1 only.
- Reset values (`clr_n`=0): state IDLE. `busy`, `coef_load`, `coef_cnt`, `data_rd`, `mac_en`, `mac_first`, `done` and `err` are 0; `data_addr` and `coef_ptr_o` are 0.
- Reset mid-operation forces these values immediately (asynchronously) and produces no `done`.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- Basic run, nominal window: `coef_ptr`=0x040, `data_ptr`=0x105, `buf_base`=0x100, `buf_len`=16, N=4.
  - `coef_load` in cycle 1; `coef_cnt` in cycles 2–5.
  - `data_addr` = 0x105, 0x104, 0x103, 0x102.
  - `mac_en` in cycles 3–6, with `mac_first` in cycle 3; `done` in cycle 7.
- Wrap: same window, `data_ptr`=0x101, N=4 → `data_addr` = 0x101, 0x100, 0x10F, 0x10E.
- Zero taps and invalid pointer:
  - `tap_num`=0 → `done`=1, `err`=0 in cycle 1; no `coef_load` or `mac_en`.
  - `data_ptr`=0x0FF → `done`=1, `err`=1 in cycle 1.
- Busy and back-to-back starts, N=2:
  - `start` held high continuously → starts are accepted in cycles 0, 6 and 12.
  - A `start` pulse in cycle 3 is ignored.
- Abort: `abort` in cycle 3 with N=8 → IDLE from cycle 4; `coef_cnt`=0 and `busy`=0 from cycle 4; `mac_en` is last high in cycle 3; no `done`.
- Reset mid-operation: `clr_n` low in the middle of cycle 4 → all outputs 0 at once; after release, a new `start` runs normally.

Source files
------------

// File: rtl/mac_tap_sequencer_if.sv
// Handshake and address bus between the phase scheduler and the MAC tap sequencer.
interface mac_tap_sequencer_if #(
  parameter int DATA_ADDRESS_WIDTH = 12,
  parameter int TAP_CNT_WIDTH      = 8
);
  logic                          start;
  logic                          abort;
  logic [DATA_ADDRESS_WIDTH-1:0] coef_ptr;
  logic [DATA_ADDRESS_WIDTH-1:0] data_ptr;
  logic [DATA_ADDRESS_WIDTH-1:0] buf_base;
  logic [DATA_ADDRESS_WIDTH-1:0] buf_len;
  logic [TAP_CNT_WIDTH-1:0]      tap_num;
  logic                          busy;
  logic                          coef_load;
  logic                          coef_cnt;
  logic [DATA_ADDRESS_WIDTH-1:0] coef_ptr_o;
  logic                          data_rd;
  logic [DATA_ADDRESS_WIDTH-1:0] data_addr;
  logic                          mac_en;
  logic                          mac_first;
  logic                          done;
  logic                          err;

  modport master (
    output start, abort, coef_ptr, data_ptr, buf_base, buf_len, tap_num,
    input  busy, coef_load, coef_cnt, coef_ptr_o, data_rd, data_addr,
           mac_en, mac_first, done, err
  );

  modport slave (
    input  start, abort, coef_ptr, data_ptr, buf_base, buf_len, tap_num,
    output busy, coef_load, coef_cnt, coef_ptr_o, data_rd, data_addr,
           mac_en, mac_first, done, err
  );
endinterface

// File: rtl/mac_tap_sequencer.sv
// Sequences one polyphase FIR output: coefficient counter control, ring-buffer
// read addresses and MAC strobes delayed to match the one-cycle RAM read latency.
module mac_tap_sequencer #(
  parameter int DATA_ADDRESS_WIDTH = 12,
  parameter int TAP_CNT_WIDTH      = 8
) (
  input  logic                 clk,
  input  logic                 clr_n,
  mac_tap_sequencer_if.slave   bus
);
  localparam int AW = DATA_ADDRESS_WIDTH;
  localparam int TW = TAP_CNT_WIDTH;
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [TW-1:0] TAP_ONE  = TW'(1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

  state_t        state, state_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] len_q, len_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] coef_ptr_q, coef_ptr_d;
  logic [TW-1:0] tap_q, tap_d;
  logic          busy_q, coef_load_q, run_q, mac_en_q, mac_first_q, done_q, err_q;
  logic          mac_en_d, err_d, kill;
  logic [AW-1:0] offset, last_addr;
  logic          in_window;

  // Offset taken modulo 2^AW so a window straddling the top of memory still checks correctly.
  assign offset    = bus.data_ptr - bus.buf_base;
  assign in_window = (bus.buf_len != '0) && (offset < bus.buf_len);
  assign last_addr = base_q + len_q - ADDR_ONE;

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d    = state;
    base_d     = base_q;
    len_d      = len_q;
    addr_d     = addr_q;
    coef_ptr_d = coef_ptr_q;
    tap_d      = tap_q;
    err_d      = 1'b0;
    kill       = 1'b0;

    case (state)
      IDLE: begin
        if (bus.start) begin
          if (bus.tap_num == '0) begin
            state_d = DONE;
          end else if (!in_window) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d    = LOAD;
            base_d     = bus.buf_base;
            len_d      = bus.buf_len;
            addr_d     = bus.data_ptr;
            coef_ptr_d = bus.coef_ptr;
            tap_d      = bus.tap_num;
          end
        end
      end
      LOAD:  state_d = RUN;
      RUN: begin
        // Walk backwards through the ring; the oldest slot wraps to the window top.
        addr_d = (addr_q == base_q) ? last_addr : addr_q - ADDR_ONE;
        if (tap_q == TAP_ONE) state_d = DRAIN;
        else                  tap_d   = tap_q - TAP_ONE;
      end
      DRAIN: state_d = DONE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (bus.abort && (state == LOAD || state == RUN || state == DRAIN)) begin
      state_d = IDLE;
      kill    = 1'b1;
    end

    // The read issued in the aborting cycle must never reach the accumulator.
    mac_en_d = run_q && !kill;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  // NOTE: the latched window/pointer registers are reset too, keeping outputs defined straight out of reset.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state       <= IDLE;
      base_q      <= '0;
      len_q       <= '0;
      addr_q      <= '0;
      coef_ptr_q  <= '0;
      tap_q       <= '0;
      busy_q      <= 1'b0;
      coef_load_q <= 1'b0;
      run_q       <= 1'b0;
      mac_en_q    <= 1'b0;
      mac_first_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      addr_q      <= addr_d;
      coef_ptr_q  <= coef_ptr_d;
      tap_q       <= tap_d;
      busy_q      <= (state_d != IDLE);
      coef_load_q <= (state_d == LOAD);
      run_q       <= (state_d == RUN);
      mac_en_q    <= mac_en_d;
      mac_first_q <= mac_en_d && !mac_en_q;
      done_q      <= (state_d == DONE);
      err_q       <= err_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.coef_load  = coef_load_q;
  assign bus.coef_cnt   = run_q;
  assign bus.coef_ptr_o = coef_ptr_q;
  assign bus.data_rd    = run_q;
  assign bus.data_addr  = addr_q;
  assign bus.mac_en     = mac_en_q;
  assign bus.mac_first  = mac_first_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
endmodule
